vscale_dmem_hasti_slave: RTL

- HASTI (AHB-Lite subset) responder modelling the shared data memory behind the multicore arbiter's dmem_* port.
- Accepts single-beat address phases, inserts a configurable number of wait states per data phase, and performs byte/half/word reads and writes into a word-organised array.
- Returns a two-cycle ERROR response for illegal accesses.
- Drives the hready/hresp/hrdata that the arbiter steers back to the owning core.

---
 rtl/vscale_dmem_hasti_slave_pkg.sv | 33 +++
 rtl/vscale_hasti_wmask.sv | 29 ++
 rtl/vscale_dmem_hasti_slave.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vscale_dmem_hasti_slave_pkg.sv
// Shared HASTI bus constants and the data-memory responder state encodings.
package vscale_dmem_hasti_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_RESP_WIDTH-1:0] RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] RESP_ERROR = 1'b1;

  localparam logic [HASTI_SIZE_WIDTH-1:0] SIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] SIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] SIZE_WORD = 3'd2;

  localparam int DMEM_WAIT_WIDTH = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_DATA = 2'd1,
    DMEM_ERR1 = 2'd2,
    DMEM_ERR2 = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/vscale_hasti_wmask.sv
// Byte-lane write mask and misalignment flag for a 32-bit HASTI data beat.
module vscale_hasti_wmask
  import vscale_dmem_hasti_slave_pkg::*;
(
  input  logic [HASTI_SIZE_WIDTH-1:0] hsize,
  input  logic [1:0]                  addr,
  output logic [3:0]                  mask,
  output logic                        misaligned
);

  // Sizes above a word yield an empty mask; the caller rejects them separately.
  always_comb begin
    mask       = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      SIZE_BYTE: mask = 4'b0001 << addr;
      SIZE_HALF: begin
        mask       = 4'b0011 << addr;
        misaligned = addr[0];
      end
      SIZE_WORD: begin
        mask       = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vscale_dmem_hasti_slave.sv
// HASTI data-memory responder: single beats, fixed wait states per OKAY data
// phase, two-cycle ERROR for out-of-range, oversized or misaligned accesses.
//
// state | meaning
// IDLE  | no data phase; ready for an address phase
// DATA  | legal data phase; counts down wait states, completes at zero
// ERR1  | first ERROR cycle, hready low
// ERR2  | second ERROR cycle, hready high; may take a new address phase
module vscale_dmem_hasti_slave
  import vscale_dmem_hasti_slave_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [DMEM_WAIT_WIDTH-1:0] WAIT_INIT = DMEM_WAIT_WIDTH'(WAIT_STATES);

  logic [31:0] mem [MEM_WORDS];

  dmem_state_e                state;
  logic [DMEM_WAIT_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]           idx;
  logic [3:0]                 wmask;
  logic                       wr;

  logic [3:0] lane_mask;
  logic       misaligned;
  logic       accept;
  logic       in_range;
  logic       legal;
  logic       complete;
  logic       unused_ok;

  vscale_hasti_wmask u_wmask (
    .hsize      (hsize),
    .addr       (haddr[1:0]),
    .mask       (lane_mask),
    .misaligned (misaligned)
  );

  assign accept   = hready && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);
  assign in_range = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, haddr} <  ({1'b0, BASE_ADDR} + MEM_BYTES));
  assign legal    = in_range && (hsize <= SIZE_WORD) && !misaligned;
  assign complete = (state == DMEM_DATA) && (cnt == '0);
  assign unused_ok = ^{hburst, hmastlock, hprot};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= DMEM_IDLE;
      cnt    <= '0;
      idx    <= '0;
      wmask  <= '0;
      wr     <= 1'b0;
      hready <= 1'b1;
      hresp  <= RESP_OKAY;
    end else if (hready) begin
      // IDLE, final DATA cycle and ERR2 all share the address-phase rules.
      if (accept && legal) begin
        state  <= DMEM_DATA;
        cnt    <= WAIT_INIT;
        idx    <= haddr[IDX_W+1:2];
        wmask  <= lane_mask;
        wr     <= hwrite;
        hready <= (WAIT_INIT == '0);
        hresp  <= RESP_OKAY;
      end else if (accept) begin
        state  <= DMEM_ERR1;
        wr     <= 1'b0;
        hready <= 1'b0;
        hresp  <= RESP_ERROR;
      end else begin
        state  <= DMEM_IDLE;
        wr     <= 1'b0;
        hready <= 1'b1;
        hresp  <= RESP_OKAY;
      end
    end else begin
      case (state)
        DMEM_DATA: begin
          cnt    <= cnt - 1'b1;
          hready <= (cnt == DMEM_WAIT_WIDTH'(1));
        end
        DMEM_ERR1: begin
          state  <= DMEM_ERR2;
          hready <= 1'b1;
          hresp  <= RESP_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (complete && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (state == DMEM_DATA && !wr) hrdata = mem[idx];
  end

endmodule
